// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator on the PLL pixel clock, started after a qualified lock.
// Optional colour-bar pattern on r/g/b when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int LOCK_WAIT = 16,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);
    // state     | meaning
    // WAIT_LOCK | raster idle, waiting for synchronised lock
    // QUALIFY   | lock seen, counting LOCK_WAIT consecutive locked cycles
    // RUN       | raster counters advancing, outputs live

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int QW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state_q;
    logic          lock_meta_q;
    logic          lock_s_q;
    logic [QW-1:0] qual_cnt_q;
    logic [9:0]    h_cnt_q;
    logic [9:0]    v_cnt_q;
    logic [9:0]    h_cnt_d;
    logic [9:0]    v_cnt_d;
    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic          line_start_q;
    logic          frame_start_q;
    logic          running_q;
    logic          hsync_d;
    logic          vsync_d;
    logic          de_d;

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
        hsync_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            lock_meta_q   <= 1'b0;
            lock_s_q      <= 1'b0;
            qual_cnt_q    <= '0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            lock_meta_q   <= pll_locked;
            lock_s_q      <= lock_meta_q;
            // Outputs fall back to idle unless RUN refreshes them below.
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_q    <= QUALIFY;
                        qual_cnt_q <= '0;
                    end
                end
                QUALIFY: begin
                    if (!lock_s_q) begin
                        state_q <= WAIT_LOCK;
                    end else if (qual_cnt_q == QUAL_LAST) begin
                        state_q   <= RUN;
                        h_cnt_q   <= 10'd0;
                        v_cnt_q   <= 10'd0;
                        running_q <= 1'b1;
                    end else begin
                        qual_cnt_q <= qual_cnt_q + QW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s_q) begin
                        state_q <= WAIT_LOCK;
                        h_cnt_q <= 10'd0;
                        v_cnt_q <= 10'd0;
                    end else begin
                        h_cnt_q       <= h_cnt_d;
                        v_cnt_q       <= v_cnt_d;
                        running_q     <= 1'b1;
                        hsync_q       <= hsync_d;
                        vsync_q       <= vsync_d;
                        de_q          <= de_d;
                        x_q           <= de_d ? h_cnt_q : 10'd0;
                        y_q           <= de_d ? v_cnt_q : 10'd0;
                        line_start_q  <= (h_cnt_q == 10'd0);
                        frame_start_q <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar;
    logic [23:0] rgb_q;

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt_q >= 10'(k * BAR_W)) bar = 3'(k);
        end
    end

    // Bar index bits map straight to inverted colour components (white..black).
    always_ff @(posedge refclk) begin
        if (rst) begin
            rgb_q <= 24'd0;
        end else if ((state_q == RUN) && lock_s_q && de_d) begin
            rgb_q <= {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
        end else begin
            rgb_q <= 24'd0;
        end
    end

    assign r = rgb_q[23:16];
    assign g = rgb_q[15:8];
    assign b = rgb_q[7:0];
`else
    assign r = 8'd0;
    assign g = 8'd0;
    assign b = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: directed timing expectations queued by tick,
// popped and compared by a negedge monitor. Vertical timing shrunk to keep runs short.
module tb_vga_timing_gen;
    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       hsync, vsync, de, line_start, frame_start, running;
    logic [9:0] x, y;
    logic [7:0] r, g, b;

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .LOCK_WAIT(16), .SYNC_POL(1'b0)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .running(running),
        .r(r), .g(g), .b(b)
    );

    always #5 refclk = ~refclk;

    int tick = 0;
    always @(posedge refclk) tick <= tick + 1;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif
    localparam logic [23:0] C_WHITE  = PAT_EN ? 24'hFFFFFF : 24'h0;
    localparam logic [23:0] C_YELLOW = PAT_EN ? 24'hFFFF00 : 24'h0;
    localparam logic [23:0] C_CYAN   = PAT_EN ? 24'h00FFFF : 24'h0;
    // {running,de,hsync,vsync,line_start,frame_start,|x,|y,|rgb} when idle
    localparam logic [23:0] IDLE     = 24'h000060;

    typedef enum int {F_RUN, F_FS, F_LS, F_HS, F_VS, F_DE, F_X, F_Y, F_RGB, F_IDLE} fld_t;
    typedef struct {
        int          t;
        fld_t        f;
        logic [23:0] v;
        string       nm;
    } chk_t;

    chk_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [23:0] actual(input fld_t f);
        case (f)
            F_RUN:   return {23'd0, running};
            F_FS:    return {23'd0, frame_start};
            F_LS:    return {23'd0, line_start};
            F_HS:    return {23'd0, hsync};
            F_VS:    return {23'd0, vsync};
            F_DE:    return {23'd0, de};
            F_X:     return {14'd0, x};
            F_Y:     return {14'd0, y};
            F_RGB:   return {r, g, b};
            default: return {15'd0, running, de, hsync, vsync, line_start, frame_start,
                             |x, |y, |{r, g, b}};
        endcase
    endfunction

    task automatic expect_at(input int t, input fld_t f, input logic [23:0] v, input string nm);
        chk_t c;
        int   i;
        c.t = t; c.f = f; c.v = v; c.nm = nm;
        i = 0;
        while (i < sb.size() && sb[i].t <= t) i++;
        sb.insert(i, c);
    endtask

    task automatic wait_tick(input int t);
        while (tick < t) @(negedge refclk);
    endtask

    always @(negedge refclk) begin : monitor
        chk_t c;
        logic [23:0] a;
        while (sb.size() > 0 && sb[0].t <= tick) begin
            c = sb.pop_front();
            n_total++;
            a = actual(c.f);
            if (c.t != tick)
                $display("FAIL %s: expectation for tick %0d not sampled (now tick %0d)", c.nm, c.t, tick);
            else if (a !== c.v)
                $display("FAIL %s: tick %0d got %h expected %h", c.nm, tick, a, c.v);
            else
                n_pass++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    int t0, bs, t1, b2, td, t2;

    initial begin : stim
        rst = 1'b1;
        pll_locked = 1'b1;
        repeat (4) @(negedge refclk);
        expect_at(tick + 1, F_IDLE, IDLE, "reset_idle");
        @(negedge refclk);
        t0 = tick;
        rst = 1'b0;

        // Startup and one full (shrunk) frame.
        bs = t0 + 20;
        expect_at(t0 + 1,  F_IDLE, IDLE, "wait_lock_idle");
        expect_at(t0 + 18, F_IDLE, IDLE, "qualify_idle");
        expect_at(t0 + 19, F_RUN, 24'd1, "run_entry");
        expect_at(t0 + 19, F_FS,  24'd0, "fs_before_first");
        expect_at(t0 + 19, F_DE,  24'd0, "de_before_first");
        expect_at(t0 + 19, F_HS,  24'd1, "hs_before_first");
        expect_at(t0 + 19, F_VS,  24'd1, "vs_before_first");
        expect_at(bs,       F_FS,  24'd1, "fs_first");
        expect_at(bs,       F_LS,  24'd1, "ls_first");
        expect_at(bs,       F_DE,  24'd1, "de_first");
        expect_at(bs,       F_X,   24'd0, "x_first");
        expect_at(bs,       F_Y,   24'd0, "y_first");
        expect_at(bs,       F_RGB, C_WHITE, "rgb_x0");
        expect_at(bs + 1,   F_LS,  24'd0, "ls_one_cycle");
        expect_at(bs + 1,   F_FS,  24'd0, "fs_one_cycle");
        expect_at(bs + 80,  F_RGB, C_YELLOW, "rgb_x80");
        expect_at(bs + 160, F_RGB, C_CYAN, "rgb_x160");
        expect_at(bs + 639, F_X,   24'd639, "x_max");
        expect_at(bs + 639, F_DE,  24'd1, "de_last_px");
        expect_at(bs + 639, F_RGB, 24'h0, "rgb_x639");
        expect_at(bs + 640, F_DE,  24'd0, "de_hblank");
        expect_at(bs + 640, F_X,   24'd0, "x_hblank");
        expect_at(bs + 655, F_HS,  24'd1, "hs_before");
        expect_at(bs + 656, F_HS,  24'd0, "hs_start");
        expect_at(bs + 700, F_RGB, 24'h0, "rgb_hblank");
        expect_at(bs + 751, F_HS,  24'd0, "hs_last");
        expect_at(bs + 752, F_HS,  24'd1, "hs_end");
        expect_at(bs + 799, F_LS,  24'd0, "ls_before_wrap");
        expect_at(bs + 800, F_LS,  24'd1, "ls_period");
        expect_at(bs + 800, F_FS,  24'd0, "fs_not_line1");
        expect_at(bs + 805, F_X,   24'd5, "x_line1");
        expect_at(bs + 805, F_Y,   24'd1, "y_line1");
        expect_at(bs + 3039, F_Y,  24'd3, "y_max");
        expect_at(bs + 3039, F_X,  24'd639, "x_max_last_line");
        expect_at(bs + 3200, F_DE, 24'd0, "de_vblank");
        expect_at(bs + 3200, F_Y,  24'd0, "y_vblank");
        expect_at(bs + 3200, F_LS, 24'd1, "ls_vblank");
        expect_at(bs + 3856, F_HS, 24'd0, "hs_in_vblank");
        expect_at(bs + 4799, F_VS, 24'd1, "vs_before");
        expect_at(bs + 4800, F_VS, 24'd0, "vs_start");
        expect_at(bs + 4800, F_HS, 24'd1, "hs_at_vs_start");
        expect_at(bs + 6399, F_VS, 24'd0, "vs_last");
        expect_at(bs + 6400, F_VS, 24'd1, "vs_end");
        expect_at(bs + 8799, F_DE, 24'd0, "de_last_line");
        expect_at(bs + 8800, F_FS, 24'd1, "fs_period");
        expect_at(bs + 8800, F_DE, 24'd1, "de_frame2");
        expect_at(bs + 8801, F_RGB, C_WHITE, "rgb_frame2");
        wait_tick(bs + 8802);

        // Mid-line synchronous reset, then a one-cycle lock glitch while qual_cnt=8.
        rst = 1'b1;
        expect_at(tick + 1, F_IDLE, IDLE, "midline_reset");
        @(negedge refclk);
        @(negedge refclk);
        t1 = tick;
        rst = 1'b0;
        expect_at(t1 + 12, F_IDLE, IDLE, "glitch_idle");
        expect_at(t1 + 19, F_RUN, 24'd0, "glitch_no_early_run");
        expect_at(t1 + 28, F_RUN, 24'd0, "glitch_requalify");
        expect_at(t1 + 29, F_RUN, 24'd1, "glitch_run");
        expect_at(t1 + 29, F_FS,  24'd0, "glitch_fs_before");
        expect_at(t1 + 30, F_FS,  24'd1, "glitch_fs");
        wait_tick(t1 + 9);
        pll_locked = 1'b0;
        wait_tick(t1 + 10);
        pll_locked = 1'b1;

        // Lock loss in line 2, then relock.
        b2 = t1 + 30;
        expect_at(b2 + 1650, F_Y,  24'd2, "y_before_loss");
        expect_at(b2 + 1650, F_X,  24'd50, "x_before_loss");
        td = b2 + 1700;
        wait_tick(td);
        pll_locked = 1'b0;
        expect_at(td + 3,  F_IDLE, IDLE, "loss_idle");
        expect_at(td + 10, F_IDLE, IDLE, "loss_hold_idle");
        wait_tick(td + 20);
        t2 = tick;
        pll_locked = 1'b1;
        expect_at(t2 + 18,  F_RUN, 24'd0, "relock_wait");
        expect_at(t2 + 19,  F_RUN, 24'd1, "relock_run");
        expect_at(t2 + 20,  F_FS,  24'd1, "relock_fs");
        expect_at(t2 + 20,  F_X,   24'd0, "relock_x");
        expect_at(t2 + 20,  F_Y,   24'd0, "relock_y");
        expect_at(t2 + 23,  F_X,   24'd3, "relock_x3");
        expect_at(t2 + 820, F_LS,  24'd1, "relock_ls");
        expect_at(t2 + 820, F_FS,  24'd0, "relock_fs_line1");
        wait_tick(t2 + 825);

        repeat (4) @(negedge refclk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
            n_total += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Downstream consumer of the 25.175 MHz pixel-clock PLL stage.
- Runs on the PLL output clock and qualifies the PLL `locked` status before starting.
- Generates 640x480@60 Hz VGA raster timing: hsync, vsync, data enable, pixel coordinates and frame/line strobes.
- Feeds the game renderer and the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- LOCK_WAIT, 16, consecutive synced-lock cycles required before raster starts (>=1)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- refclk  in  1  pixel clock, driven by PLL outclk_0
- rst  in  1  synchronous reset, active-high
- pll_locked  in  1  PLL lock status (asynchronous to refclk)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video enable
- x  out  10  pixel column, 0..H_ACTIVE-1 when de=1, else 0
- y  out  10  pixel row, 0..V_ACTIVE-1 when de=1, else 0
- line_start  out  1  one-cycle pulse at h=0 of every line
- frame_start  out  1  one-cycle pulse at h=0, v=0
- running  out  1  high while state=RUN
- r, g, b  out  8 each  pixel colour (see Optional Feature)

Behaviour:
- Derived constants: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 and 525.
- Clock edges are counted from the first edge after rst deasserts (edge 1).
- Reset (rst=1 at an edge), with required values:
  - state=WAIT_LOCK; sync flops=0; qual_cnt=0; h_cnt=v_cnt=0.
  - hsync=vsync=~SYNC_POL; de=0; x=y=0; line_start=frame_start=0; running=0; r=g=b=0.
- Mid-operation reset takes effect at the next edge, regardless of state.
- Lock sync: pll_locked passes through a 2-FF synchroniser to produce lock_s.
- State machine:
  - WAIT_LOCK: when lock_s=1, go to QUALIFY with qual_cnt=0.
  - QUALIFY: if lock_s=0, go to WAIT_LOCK. Else if qual_cnt==LOCK_WAIT-1, go to RUN with h_cnt=v_cnt=0. Else qual_cnt++.
  - RUN: if lock_s=0, go to WAIT_LOCK, clear the counters and drive outputs to their reset values at the next edge. Otherwise advance the counters.
- Counters (RUN only):
  - h_cnt wraps from H_TOTAL-1 to 0.
  - On that wrap, v_cnt increments, wrapping from V_TOTAL-1 to 0.
  - Simultaneous h and v wrap gives (0,0), the next frame.
- Outputs are registered: the outputs after edge n reflect the (h_cnt, v_cnt) held before edge n. Latency is 1 cycle.
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync changes only at h_cnt=0 boundaries.
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - x/y = h_cnt/v_cnt when de=1, else 0.
  - line_start = (h_cnt==0).
  - frame_start = (h_cnt==0 && v_cnt==0).
- Outside RUN, all outputs hold their reset values.
- Startup timing with pll_locked=1 from reset release:
  - lock_s=1 after edge 2; QUALIFY after edge 3; RUN after edge 3+LOCK_WAIT.
  - frame_start first high after edge 4+LOCK_WAIT (edge 20 at default LOCK_WAIT).
- Lock loss: pll_locked falling at any point forces outputs idle within 3 edges, at most.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: r/g/b carry 8 vertical colour bars, each H_ACTIVE/8 px wide (80 at default), registered with the same latency as de.
  - Bar order by x/80: white, yellow, cyan, green, magenta, red, blue, black. Components are 0xFF or 0x00.
  - r=g=b=0 whenever de=0.
- Undefined: r=g=b tied to 0; no pattern logic is synthesised. Ports remain present.

Test Plan:
- rst 5 cycles, then pll_locked=1 constant -> running=1 after edge 19, frame_start=1 after edge 20, hsync=vsync=1 and de=0 before that.
- Steady RUN:
  - line_start period = 800 cycles.
  - hsync low for exactly 96 cycles, starting 656 cycles after line_start.
  - de high for 640 cycles per active line.
- Vertical:
  - frame_start period = 420000 cycles.
  - vsync low for exactly 1600 cycles, beginning at line 490.
  - de low on lines 480..524.
  - x/y reach 639/479 maximum.
- pll_locked pulsed low for 1 cycle during QUALIFY (qual_cnt=8) -> returns to WAIT_LOCK; RUN entry delayed, full LOCK_WAIT re-qualification required.
- pll_locked dropped mid-frame at line 200 -> within 3 edges, running=0, de=0, hsync=vsync=1. On relock, raster restarts at (0,0) with frame_start.
- VGA_TEST_PATTERN_EN defined, rst asserted mid-line:
  - Before reset: x=0 gives rgb=FFFFFF; x=80 gives FFFF00; x=639 gives 000000.
  - rgb=0 during blanking.
  - Next edge after rst gives all outputs at reset values.
